// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial RISC-V loads/stores over an 8-bit controller port.
// Optional MEM_ALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of being serviced.
module mem_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        forward,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_val,
  input  logic [6:0]  ins_type,
  input  logic [2:0]  ins_details,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_val,
  input  logic        mem_ack,
  input  logic [7:0]  mem_din,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        stall_req,
  output logic        output_forward,
  output logic [4:0]  output_rd_addr,
  output logic [31:0] output_rd_val,
  output logic        misaligned
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [1:0]  last_q, last_d;     // index of the final byte (n-1)
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [31:0] sdata_q, sdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] asm_q, asm_d;
  logic        mis_q, mis_d;

  logic        is_mem;
  logic        addr_misaligned;
  logic [31:0] load_ext;

  assign is_mem = (ins_type == OP_LOAD) || (ins_type == OP_STORE);

`ifdef MEM_ALIGN_TRAP_EN
  assign addr_misaligned = ((ins_details[1:0] == 2'b01) && mem_addr[0]) ||
                           (ins_details[1] && (mem_addr[1:0] != 2'b00));
`else
  assign addr_misaligned = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    last_d   = last_q;
    idx_d    = idx_q;
    we_d     = we_q;
    sdata_d  = sdata_q;
    funct3_d = funct3_q;
    asm_d    = asm_q;
    mis_d    = mis_q;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (is_mem) begin
            base_d   = mem_addr;
            last_d   = (ins_details[1:0] == 2'b00) ? 2'd0 :
                       (ins_details[1:0] == 2'b01) ? 2'd1 : 2'd3;
            we_d     = (ins_type == OP_STORE);
            sdata_d  = mem_val;
            funct3_d = ins_details;
            idx_d    = 2'd0;
            asm_d    = 32'd0;
            mis_d    = addr_misaligned;
            state_d  = addr_misaligned ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            asm_d[{idx_q, 3'b000} +: 8] = mem_din;
            if (idx_q == last_q) state_d = S_DONE;
            else                 idx_d   = idx_q + 2'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      base_q   <= 32'd0;
      last_q   <= 2'd0;
      idx_q    <= 2'd0;
      we_q     <= 1'b0;
      sdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      asm_q    <= 32'd0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      sdata_q  <= sdata_d;
      funct3_q <= funct3_d;
      asm_q    <= asm_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{asm_q[7]}}, asm_q[7:0]};
      3'b001:  load_ext = {{16{asm_q[15]}}, asm_q[15:0]};
      3'b100:  load_ext = {24'd0, asm_q[7:0]};
      3'b101:  load_ext = {16'd0, asm_q[15:0]};
      default: load_ext = asm_q;
    endcase
  end

  // Reset forces every output low in the reset cycle itself.
  always_comb begin
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_a          = 32'd0;
    mem_dout       = 8'd0;
    stall_req      = 1'b0;
    output_forward = 1'b0;
    output_rd_addr = 5'd0;
    output_rd_val  = 32'd0;
    misaligned     = 1'b0;
    if (!rst_in) begin
      case (state_q)
        S_IDLE: begin
          if (is_mem) begin
            stall_req = 1'b1;
          end else begin
            output_forward = forward;
            output_rd_addr = rd_addr;
            output_rd_val  = rd_val;
          end
        end
        S_ACCESS: begin
          stall_req = 1'b1;
          mem_req   = 1'b1;
          mem_we    = we_q;
          mem_a     = base_q + {30'd0, idx_q};
          mem_dout  = we_q ? sdata_q[{idx_q, 3'b000} +: 8] : 8'd0;
        end
        S_DONE: begin
          misaligned = mis_q;
          if (!we_q && !mis_q) begin
            output_forward = forward;
            output_rd_addr = rd_addr;
            output_rd_val  = load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model with byte memory,
// randomized ops, ready gaps and ack delays, plus directed literal cases.
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, forward, mem_ack;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val, mem_addr, mem_val;
  logic [6:0]  ins_type;
  logic [2:0]  ins_details;
  logic [7:0]  mem_din;
  logic        mem_req, mem_we, stall_req, output_forward, misaligned;
  logic [31:0] mem_a, output_rd_val;
  logic [7:0]  mem_dout;
  logic [4:0]  output_rd_addr;

  int n_vec = 0;
  int n_err = 0;

  // Results of the most recent run_op, for literal checks.
  logic [31:0] last_val;
  logic        last_fwd;
  int          stall_cycles;
  logic [31:0] first_a, last_a;
  bit          req_seen;

  logic [7:0] mem [logic [31:0]];

  always #5 clk_in = ~clk_in;

  mem_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .forward(forward),
    .rd_addr(rd_addr), .rd_val(rd_val), .ins_type(ins_type),
    .ins_details(ins_details), .mem_addr(mem_addr), .mem_val(mem_val),
    .mem_ack(mem_ack), .mem_din(mem_din), .mem_req(mem_req), .mem_we(mem_we),
    .mem_a(mem_a), .mem_dout(mem_dout), .stall_req(stall_req),
    .output_forward(output_forward), .output_rd_addr(output_rd_addr),
    .output_rd_val(output_rd_val), .misaligned(misaligned)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input bit e_stall, input bit e_req, input bit e_fwd,
                            input logic [4:0] e_rd, input logic [31:0] e_val, input bit e_mis);
    check("stall_req", stall_req, e_stall);
    check("mem_req", mem_req, e_req);
    check("output_forward", output_forward, e_fwd);
    check("output_rd_addr", output_rd_addr, e_rd);
    check("output_rd_val", output_rd_val, e_val);
    check("misaligned", misaligned, e_mis);
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Expected load result from memory contents by plain arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint w = 0;
    for (int i = 0; i < nbytes(f3); i++)
      w += longint'(rd_byte(a + 32'(i))) * (longint'(1) << (8 * i));
    if (f3 == 3'b000 && w >= 128)   w -= 256;
    if (f3 == 3'b001 && w >= 32768) w -= 65536;
    return w[31:0];
  endfunction

  task automatic run_alu(input logic [6:0] op, input logic [4:0] rd,
                         input logic [31:0] val, input bit fwd);
    @(negedge clk_in);
    ins_type = op; rd_addr = rd; rd_val = val; forward = fwd;
    mem_addr = $urandom; mem_val = $urandom; ins_details = 3'($urandom);
    #1;
    check_outs(1'b0, 1'b0, fwd, rd, val, 1'b0);
    rdy_in  = ($urandom_range(0, 99) < 80);
    mem_ack = 1'($urandom);          // stray acks outside ACCESS are ignored
    mem_din = 8'($urandom);
  endtask

  // One load/store transaction; dly < 0 picks a random ack delay per byte.
  task automatic run_op(input bit is_store, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input bit fwd,
                        input int dly, input int rdy_pct);
    int  n, phase, k, wait_cnt, cyc, cur_dly;
    bit  trap, acked;
    n = nbytes(f3);
    trap = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
    trap = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
    phase = 0; k = 0; wait_cnt = 0; cyc = 0;
    cur_dly = (dly < 0) ? $urandom_range(0, 3) : dly;
    stall_cycles = 0; req_seen = 1'b0;
    forever begin
      @(negedge clk_in);
      if (cyc == 0) begin
        ins_type = is_store ? OP_STORE : OP_LOAD;
        ins_details = f3; mem_addr = addr; mem_val = sdata;
        rd_addr = rd; rd_val = $urandom; forward = fwd;
      end
      #1;
      if (mem_req) req_seen = 1'b1;
      case (phase)
        0: begin
          check_outs(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
          stall_cycles++;
        end
        1: begin
          check_outs(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
          check("mem_a", mem_a, addr + 32'(k));
          check("mem_we", mem_we, is_store);
          stall_cycles++;
        end
        default: begin
          last_val = output_rd_val;
          last_fwd = output_forward;
          check_outs(1'b0, 1'b0, (!is_store && !trap) ? fwd : 1'b0,
                     (!is_store && !trap) ? rd : 5'd0,
                     (!is_store && !trap) ? model_load(f3, addr) : 32'd0, trap);
        end
      endcase
      rdy_in  = ($urandom_range(0, 99) < rdy_pct);
      mem_ack = 1'b0;
      mem_din = 8'($urandom);
      acked   = 1'b0;
      if (phase == 1) begin
        if (!rdy_in) begin
          mem_ack = 1'($urandom);    // must be ignored while frozen
        end else if (wait_cnt >= cur_dly) begin
          mem_ack = 1'b1;
          acked   = 1'b1;
          if (k == 0) first_a = mem_a;
          last_a = mem_a;
          if (is_store) begin
            check("mem_dout", mem_dout, 8'((sdata >> (8 * k)) & 32'hFF));
            mem[mem_a] = mem_dout;
          end else begin
            mem_din = rd_byte(addr + 32'(k));
          end
          k++;
          wait_cnt = 0;
          if (dly < 0) cur_dly = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      if (rdy_in) begin
        if (phase == 0)               phase = trap ? 2 : 1;
        else if (phase == 1 && acked && k == n) phase = 2;
        else if (phase == 2)          break;
      end
      cyc++;
      if (cyc > 300) begin
        n_vec++; n_err++;
        $display("FAIL op_timeout: stuck in phase %0d, expected completion", phase);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; forward = 1'b1; rd_addr = 5'd9; rd_val = 32'hDEAD_BEEF;
    ins_type = OP_ADDI; ins_details = 3'd0; mem_addr = 32'd0; mem_val = 32'd0;
    mem_ack = 1'b0; mem_din = 8'd0;

    repeat (2) begin
      @(negedge clk_in); #1;
      check_outs(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      check("reset_mem_a", mem_a, 32'd0);
    end
    rst_in = 1'b0;

    run_alu(OP_ADDI, 5'd5, 32'h1234, 1'b1);

    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_op(1'b0, 3'b010, 32'h100, 32'd0, 5'd3, 1'b1, 0, 100);
    check("lw_val", last_val, 32'h1234_5678);
    check("lw_stall_cycles", 32'(stall_cycles), 32'd5);
    check("lw_first_a", first_a, 32'h100);
    check("lw_last_a", last_a, 32'h103);

    mem[32'h10] = 8'h80;
    run_op(1'b0, 3'b000, 32'h10, 32'd0, 5'd6, 1'b1, 0, 100);
    check("lb_val", last_val, 32'hFFFF_FF80);
    run_op(1'b0, 3'b100, 32'h10, 32'd0, 5'd6, 1'b1, 0, 100);
    check("lbu_val", last_val, 32'h0000_0080);

    run_op(1'b1, 3'b001, 32'h20, 32'hAABB_CCDD, 5'd4, 1'b1, 3, 100);
    check("sh_byte0", 32'(mem[32'h20]), 32'hDD);
    check("sh_byte1", 32'(mem[32'h21]), 32'hCC);
    check("sh_forward", 32'(last_fwd), 32'd0);

    // Reset in the middle of a word load.
    @(negedge clk_in);
    ins_type = OP_LOAD; ins_details = 3'b010; mem_addr = 32'h200; rd_addr = 5'd2; forward = 1'b1;
    #1; rdy_in = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in); #1;
      check("rst_seq_mem_a", mem_a, 32'h200 + 32'(i));
      mem_ack = 1'b1; mem_din = 8'($urandom);
    end
    @(negedge clk_in);
    rst_in = 1'b1; mem_ack = 1'b0; ins_type = OP_ADDI; forward = 1'b1; rd_addr = 5'd7; rd_val = 32'hDEAD;
    #1;
    check_outs(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0; forward = 1'b0; rd_addr = 5'd0; rd_val = 32'd0;
    #1;
    check_outs(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    mem[32'h300] = 8'h7F;
    run_op(1'b0, 3'b000, 32'h300, 32'd0, 5'd8, 1'b1, 0, 100);
    check("post_reset_lb", last_val, 32'h0000_007F);

    run_op(1'b0, 3'b010, 32'h102, 32'd0, 5'd9, 1'b1, 0, 100);
`ifdef MEM_ALIGN_TRAP_EN
    check("mis_req_seen", 32'(req_seen), 32'd0);
    check("mis_stall_cycles", 32'(stall_cycles), 32'd1);
`else
    check("unal_first_a", first_a, 32'h102);
    check("unal_last_a", last_a, 32'h105);
`endif

    run_op(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 5'd10, 1'b1, 0, 100);
    check("wrap_first_a", first_a, 32'hFFFF_FFFE);
    check("wrap_last_a", last_a, 32'h0000_0001);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 2);
      a   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 255));
      if (sel == 0) begin
        run_alu(7'b0110011, 5'($urandom), $urandom, 1'($urandom));
      end else if (sel == 1) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
        run_op(1'b0, f3, a, 32'd0, 5'($urandom), 1'($urandom), -1, 80);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        run_op(1'b1, f3, a, $urandom, 5'($urandom), 1'($urandom), -1, 80);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
